// File: rtl/control_event_fifo.sv
// Multi-source input-event queue: one pending slot per source, a round-robin arbiter
// and a DEPTH-entry FIFO with a registered head, feeding the game core.
module control_event_fifo #(
    parameter int unsigned N_SRC  = 5,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned CODE_W = 4,
    parameter int unsigned DROP_W = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      flush,
    input  logic [N_SRC-1:0]          src_valid,
    input  logic [N_SRC*CODE_W-1:0]   src_code,
    input  logic                      out_ready,
    output logic [CODE_W-1:0]         out_code,
    output logic                      out_valid,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic [DROP_W-1:0]         drop_cnt
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned RR_W   = $clog2(N_SRC);
    localparam int unsigned DSUM_W = DROP_W + $clog2(N_SRC + 1);
    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

    logic [CODE_W-1:0] pend [N_SRC];
    logic [N_SRC-1:0]  pend_v;
    logic [RR_W-1:0]   rr_ptr;
    logic [CODE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;

    logic              pop;
    logic              accept;
    logic              grant;
    logic [RR_W-1:0]   grant_idx;
    logic [RR_W-1:0]   scan_idx;
    logic [CODE_W-1:0] push_code;
    logic [CODE_W-1:0] cap_code;
    logic [N_SRC-1:0]  load_n;
    logic [N_SRC-1:0]  pend_v_n;
    logic [N_SRC-1:0]  drops;
    logic [DSUM_W-1:0] drop_sum;
    logic [DROP_W-1:0] drop_n;
    logic [RR_W-1:0]   rr_n;
    logic [PTR_W-1:0]  rd_n;
    logic [PTR_W-1:0]  wr_n;
    logic [CNT_W-1:0]  count_n;
    logic [CODE_W-1:0] head_n;

    assign pop    = out_ready && out_valid && !flush;
    assign accept = !full || pop;

    // Round-robin scan starting at rr_ptr; at most one grant per cycle.
    always_comb begin
        grant     = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = 0; k < int'(N_SRC); k++) begin
            scan_idx = RR_W'((32'(rr_ptr) + 32'(k)) % N_SRC);
            if (!grant && accept && !flush && pend_v[scan_idx]) begin
                grant     = 1'b1;
                grant_idx = scan_idx;
            end
        end
        push_code = pend[grant_idx];
        rr_n      = rr_ptr;
        if (grant) begin
            rr_n = (grant_idx == RR_W'(N_SRC - 1)) ? '0 : grant_idx + RR_W'(1);
        end
    end

    // Pending-slot capture; a busy, ungranted slot keeps its event and the new one is dropped.
    always_comb begin
        pend_v_n = pend_v;
        load_n   = '0;
        drops    = '0;
        cap_code = '0;
        for (int i = 0; i < int'(N_SRC); i++) begin
            cap_code = src_code[i*CODE_W +: CODE_W];
            if (grant && grant_idx == RR_W'(i)) begin
                pend_v_n[i] = 1'b0;
            end
            if (src_valid[i] && cap_code != '0) begin
                if (!pend_v[i] || (grant && grant_idx == RR_W'(i))) begin
                    load_n[i]   = 1'b1;
                    pend_v_n[i] = 1'b1;
                end else begin
                    drops[i] = 1'b1;
                end
            end
        end
        if (flush) begin
            pend_v_n = '0;
            load_n   = '0;
            drops    = '0;
        end
        drop_sum = DSUM_W'(drop_cnt);
        for (int i = 0; i < int'(N_SRC); i++) begin
            drop_sum = drop_sum + DSUM_W'(drops[i]);
        end
        drop_n = (drop_sum > DSUM_W'(DROP_MAX)) ? DROP_MAX : DROP_W'(drop_sum);
    end

    // FIFO pointer/count update and next registered head.
    always_comb begin
        rd_n    = rd_ptr + PTR_W'(pop);
        wr_n    = wr_ptr + PTR_W'(grant);
        count_n = count + CNT_W'(grant) - CNT_W'(pop);
        if (flush) begin
            rd_n    = '0;
            wr_n    = '0;
            count_n = '0;
        end
        if (count_n == '0) begin
            head_n = '0;
        end else if (grant && wr_ptr == rd_n) begin
            head_n = push_code;
        end else begin
            head_n = mem[rd_n];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_v    <= '0;
            rr_ptr    <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            drop_cnt  <= '0;
            out_code  <= '0;
            out_valid <= 1'b0;
            full      <= 1'b0;
        end else begin
            pend_v    <= pend_v_n;
            rr_ptr    <= rr_n;
            rd_ptr    <= rd_n;
            wr_ptr    <= wr_n;
            count     <= count_n;
            drop_cnt  <= drop_n;
            out_code  <= head_n;
            out_valid <= (count_n != '0);
            full      <= (count_n == CNT_W'(DEPTH));
        end
    end

    // Storage needs no reset; validity lives in pend_v and count.
    always_ff @(posedge clk) begin
        if (grant) begin
            mem[wr_ptr] <= push_code;
        end
        for (int i = 0; i < int'(N_SRC); i++) begin
            if (load_n[i]) begin
                pend[i] <= src_code[i*CODE_W +: CODE_W];
            end
        end
    end

endmodule

// File: tb/tb_control_event_fifo.sv
// Scoreboard bench for control_event_fifo: expected codes are queued as events are posted
// and compared against the head whenever the bench pops.
module tb_control_event_fifo;

    localparam int unsigned N_SRC  = 5;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned CODE_W = 4;
    localparam int unsigned DROP_W = 8;
    localparam int unsigned CNT_W  = 5;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic                    flush;
    logic [N_SRC-1:0]        src_valid;
    logic [N_SRC*CODE_W-1:0] src_code;
    logic                    out_ready;
    logic [CODE_W-1:0]       out_code;
    logic                    out_valid;
    logic [CNT_W-1:0]        count;
    logic                    full;
    logic [DROP_W-1:0]       drop_cnt;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [CODE_W-1:0] sb[$];
    logic [CODE_W-1:0] exp_code;

    control_event_fifo #(.N_SRC(N_SRC), .DEPTH(DEPTH), .CODE_W(CODE_W), .DROP_W(DROP_W)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .src_valid(src_valid), .src_code(src_code),
        .out_ready(out_ready), .out_code(out_code), .out_valid(out_valid), .count(count),
        .full(full), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic post(input int i, input logic [CODE_W-1:0] c);
        src_valid[i] = 1'b1;
        src_code[i*CODE_W +: CODE_W] = c;
    endtask

    task automatic idle();
        src_valid = '0;
        src_code  = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle();
        step();
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b want 0", out_valid); end
        n_cmp++; if (count !== 5'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", count); end
        n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL rst_full: got %0b want 0", full); end
        n_cmp++; if (out_code !== 4'd0) begin n_fail++; $display("FAIL rst_code: got %0d want 0", out_code); end
        n_cmp++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_drop: got %0d want 0", drop_cnt); end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        post(1, 4'd3);
        sb.push_back(4'd3);
        step();
        idle();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early: got %0b want 0", out_valid); end
        step();
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %0b want 1", out_valid); end
        n_cmp++; if (count !== 5'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", count); end
        exp_code = sb.pop_front();
        n_cmp++; if (out_code !== exp_code) begin n_fail++; $display("FAIL single_code: got %0d want %0d", out_code, exp_code); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_cmp++; if (out_code !== 4'd0) begin n_fail++; $display("FAIL single_empty_code: got %0d want 0", out_code); end
        n_cmp++; if (count !== 5'd0) begin n_fail++; $display("FAIL single_empty_count: got %0d want 0", count); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_empty_valid: got %0b want 0", out_valid); end
    endtask

    task automatic test_simultaneous();
        // restart so the arbiter pointer starts at source 0
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        post(0, 4'd1); post(2, 4'd2); post(4, 4'd3);
        sb.push_back(4'd1); sb.push_back(4'd2); sb.push_back(4'd3);
        step();
        idle();
        for (int k = 1; k <= 3; k++) begin
            step();
            n_cmp++; if (count !== CNT_W'(k)) begin n_fail++; $display("FAIL sim_count%0d: got %0d want %0d", k, count, k); end
        end
        n_cmp++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL sim_drop: got %0d want 0", drop_cnt); end
        // src 0 before src 4 shows the pointer wrapped back to 0
        post(0, 4'd5); post(4, 4'd6);
        sb.push_back(4'd5); sb.push_back(4'd6);
        step();
        idle();
        for (int c = 0; c < 20 && sb.size() > 0; c++) begin
            out_ready = 1'b1;
            if (out_valid) begin
                exp_code = sb.pop_front();
                n_cmp++; if (out_code !== exp_code) begin n_fail++; $display("FAIL sim_order: got %0d want %0d", out_code, exp_code); end
            end
            step();
        end
        out_ready = 1'b0;
        n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL sim_timeout: got %0d left want 0", sb.size()); end
        n_cmp++; if (count !== 5'd0) begin n_fail++; $display("FAIL sim_drained: got %0d want 0", count); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            src_valid = '0;
            post(0, CODE_W'((i % 15) + 1));
            sb.push_back(CODE_W'((i % 15) + 1));
            step();
        end
        idle();
        step();
        n_cmp++; if (count !== 5'd16) begin n_fail++; $display("FAIL fill_count: got %0d want 16", count); end
        n_cmp++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %0b want 1", full); end
        post(3, 4'd9);
        sb.push_back(4'd9);
        step();
        idle();
        step();
        n_cmp++; if (count !== 5'd16) begin n_fail++; $display("FAIL bp_count: got %0d want 16", count); end
        n_cmp++; if (out_code !== sb[0]) begin n_fail++; $display("FAIL bp_head: got %0d want %0d", out_code, sb[0]); end
        exp_code = sb.pop_front();
        n_cmp++; if (out_code !== exp_code) begin n_fail++; $display("FAIL bp_pop: got %0d want %0d", out_code, exp_code); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_cmp++; if (count !== 5'd16) begin n_fail++; $display("FAIL bp_pushpop_count: got %0d want 16", count); end
        n_cmp++; if (full !== 1'b1) begin n_fail++; $display("FAIL bp_pushpop_full: got %0b want 1", full); end
    endtask

    task automatic test_conflict();
        post(0, 4'd10);
        sb.push_back(4'd10);
        step();
        post(0, 4'd11);
        step();
        idle();
        n_cmp++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL conf_drop: got %0d want 1", drop_cnt); end
        n_cmp++; if (count !== 5'd16) begin n_fail++; $display("FAIL conf_count: got %0d want 16", count); end
        for (int c = 0; c < 40 && sb.size() > 0; c++) begin
            out_ready = 1'b1;
            if (out_valid) begin
                exp_code = sb.pop_front();
                n_cmp++; if (out_code !== exp_code) begin n_fail++; $display("FAIL conf_order: got %0d want %0d", out_code, exp_code); end
            end
            step();
        end
        out_ready = 1'b0;
        n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL conf_timeout: got %0d left want 0", sb.size()); end
        n_cmp++; if (count !== 5'd0) begin n_fail++; $display("FAIL conf_drained: got %0d want 0", count); end
        n_cmp++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL conf_drop_kept: got %0d want 1", drop_cnt); end
    endtask

    task automatic test_wrap_flush();
        for (int i = 0; i < 45; i++) begin
            src_valid = '0;
            src_code  = '0;
            if (i < 40) begin
                post(1, CODE_W'((i % 15) + 1));
                sb.push_back(CODE_W'((i % 15) + 1));
            end
            out_ready = 1'b1;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_fail++; $display("FAIL wrap_extra: got %0d want none", out_code);
                end else begin
                    exp_code = sb.pop_front();
                    n_cmp++; if (out_code !== exp_code) begin n_fail++; $display("FAIL wrap_order: got %0d want %0d", out_code, exp_code); end
                end
            end
            step();
        end
        idle();
        n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL wrap_left: got %0d left want 0", sb.size()); end
        n_cmp++; if (count !== 5'd0) begin n_fail++; $display("FAIL wrap_count: got %0d want 0", count); end
        for (int i = 0; i < 5; i++) post(i, CODE_W'(i + 1));
        step();
        idle();
        for (int i = 0; i < 5; i++) step();
        n_cmp++; if (count !== 5'd5) begin n_fail++; $display("FAIL flush_pre: got %0d want 5", count); end
        flush = 1'b1;
        out_ready = 1'b1;
        post(2, 4'd7);
        step();
        idle();
        n_cmp++; if (count !== 5'd0) begin n_fail++; $display("FAIL flush_count: got %0d want 0", count); end
        n_cmp++; if (out_code !== 4'd0) begin n_fail++; $display("FAIL flush_code: got %0d want 0", out_code); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %0b want 0", out_valid); end
        n_cmp++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL flush_drop: got %0d want 1", drop_cnt); end
        step();
        step();
        n_cmp++; if (count !== 5'd0) begin n_fail++; $display("FAIL flush_ignored: got %0d want 0", count); end
    endtask

    task automatic test_async_reset();
        post(0, 4'd4); post(1, 4'd5);
        step();
        idle();
        step();
        step();
        n_cmp++; if (count !== 5'd2) begin n_fail++; $display("FAIL arst_pre: got %0d want 2", count); end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %0b want 0", out_valid); end
        n_cmp++; if (count !== 5'd0) begin n_fail++; $display("FAIL arst_count: got %0d want 0", count); end
        n_cmp++; if (out_code !== 4'd0) begin n_fail++; $display("FAIL arst_code: got %0d want 0", out_code); end
        n_cmp++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL arst_drop: got %0d want 0", drop_cnt); end
        @(negedge clk);
        reset_n = 1'b1;
        post(2, 4'd8);
        step();
        idle();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_early: got %0b want 0", out_valid); end
        step();
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL arst_lat_valid: got %0b want 1", out_valid); end
        n_cmp++; if (out_code !== 4'd8) begin n_fail++; $display("FAIL arst_lat_code: got %0d want 8", out_code); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_cmp++; if (count !== 5'd0) begin n_fail++; $display("FAIL arst_final: got %0d want 0", count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_fill();
        test_conflict();
        test_wrap_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
